joy_serializer: RTL and testbench
=================================

// Module: joy_serializer
// PURPOSE
//   Slave end of the Neptuno two-joystick serial link: emulates the board's
//   parallel-in/serial-out shift-register chain. Captures two active-low
//   joysticks, loads them on joy_load_n low and shifts one bit per rising
//   joy_clk, so an existing master decoder reads it unchanged. Used on
//   adapter boards and as the bus model in board-level benches.
// PARAMETERS
//   WIDTH        16  serial frame length in bits (>= 16; bits 16+ idle at 1)
//   SYNC_STAGES  2   flip-flop stages on joy_clk, joy_load_n and button inputs
// PORTS
//   clk          in   1      system clock, >= 8x joy_clk frequency
//   reset        in   1      synchronous, active-high
//   joy_clk      in   1      serial clock from master, asynchronous to clk
//   joy_load_n   in   1      parallel load from master, active-low, async
//   joy_data     out  1      serial data to master
//   joy1_n       in   6      P1 {up,down,left,right,fire1,fire2}, low=pressed
//   joy2_n       in   6      P2, same order and polarity
//   frame_done   out  1      one-clk pulse after WIDTH shifts following a load
// BEHAVIOUR
//   - Reset: sr=all 1s, joy_data=1, frame_done=0, bit_cnt=0; joy_clk
//     synchroniser=0, joy_load_n synchroniser=1, button synchronisers=1.
//   - Edge detection masked for SYNC_STAGES+1 clks after reset release.
//   - Frame word (bit k = k-th bit presented): [7]up1 [6]down1 [5]left1
//     [4]right1 [3]fire1_1 [2]fire2_1 [15]up2 [14]down2 [13]left2 [12]right2
//     [11]fire1_2 [10]fire2_2; bits 1:0, 9:8 and >=16 are constant 1.
//   - joy_data = sr[0] at all times (registered, no combinational path).
//   - Load: while synced joy_load_n==0, sr <= frame word from synced
//     buttons every clk (level-sensitive, transparent); bit_cnt <= 0.
//   - Shift: on synced joy_clk rising edge with synced joy_load_n==1,
//     sr <= {fill, sr[WIDTH-1:1]}; bit_cnt increments, saturating at WIDTH.
//   - Latency: joy_data changes SYNC_STAGES+1 clks after joy_clk rises;
//     master samples on falling joy_clk, so joy_clk high time must be
//     >= SYNC_STAGES+2 clks.
//   - frame_done pulses the clk bit_cnt goes WIDTH-1 -> WIDTH; once per load.
//   - Load low coincident with a joy_clk rise: load wins, no shift/count.
//   - Shifts past WIDTH: fill bits appear; no wrap, no further frame_done.
//   - joy_clk falling edges are ignored. Reset mid-frame: immediate reset
//     values; next frame starts at the next load.
// CONFIGURATION
//   JOY_SERIALIZER_CASCADE_EN defined: adds input port joy_data_in (1 bit,
//     synchronised SYNC_STAGES) and fill = synced joy_data_in, so further
//     shift registers can be daisy-chained behind this block.
//   Not defined: no joy_data_in port; fill = 1'b1 (idle / not pressed).
// TESTING
//   1. reset=1 for 4 clks -> joy_data=1, frame_done=0; no edge after release
//      even if joy_clk=1 at release.
//   2. joy1_n=6'b011111 (up1 only), load pulse then 16 joy_clk -> serial
//      word 16'hFF7F, frame_done one pulse after the 16th rise.
//   3. joy2_n=6'b111110, joy1_n=6'b111111 -> word 16'hFBFF; bit 10 low.
//   4. load low held over two joy_clk rises -> no shift, joy_data tracks
//      live buttons; release then 16 clocks -> full word, single frame_done.
//   5. 20 joy_clk after load -> bits 16..19 = 1 (fill; CASCADE_EN: equal to
//      joy_data_in=0 pattern), frame_done still once.
//   6. reset asserted after 5 shifts -> joy_data=1 next clk; new load + 16
//      clocks yields correct word.

Source files
------------

// File: rtl/joy_serializer.sv
// Purpose     : slave end of the two-joystick serial link, emulating a PISO shift-register chain.
// Latency     : joy_data follows a joy_clk rise by SYNC_STAGES+1 clk; load is transparent while low.
// Backpressure: none, the master paces everything via joy_clk/joy_load_n.
//
// Ports:
//   clk, reset          system clock (>= 8x joy_clk), synchronous active-high reset
//   joy_clk, joy_load_n master serial clock and active-low parallel load (both async)
//   joy1_n, joy2_n      {up,down,left,right,fire1,fire2}, low = pressed (async)
//   joy_data            serial data to master (= sr[0], registered)
//   frame_done          one-clk pulse when the WIDTH-th shift after a load completes
//   joy_data_in         only with JOY_SERIALIZER_CASCADE_EN: serial input from a
//                       downstream register, shifted in behind the frame
//
// Optional build macro: JOY_SERIALIZER_CASCADE_EN (default undefined, fill = 1).
module joy_serializer #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       joy_clk,
    input  logic       joy_load_n,
`ifdef JOY_SERIALIZER_CASCADE_EN
    input  logic       joy_data_in,
`endif
    input  logic [5:0] joy1_n,
    input  logic [5:0] joy2_n,
    output logic       joy_data,
    output logic       frame_done
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int MASK_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [MASK_W-1:0] MASK_DONE = MASK_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0]      clk_sync;
    logic [SYNC_STAGES-1:0]      load_sync;
    logic [SYNC_STAGES-1:0][5:0] j1_sync;
    logic [SYNC_STAGES-1:0][5:0] j2_sync;
    logic                        clk_prev;
    logic [MASK_W-1:0]           mask_cnt;
    logic [WIDTH-1:0]            sr;
    logic [CNT_W-1:0]            bit_cnt;
    logic [WIDTH-1:0]            frame;
    logic                        clk_s;
    logic                        load_s_n;
    logic                        rise;
    logic                        fill;

`ifdef JOY_SERIALIZER_CASCADE_EN
    logic [SYNC_STAGES-1:0] din_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            din_sync <= '1;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) din_sync[i] <= din_sync[i-1];
            din_sync[0] <= joy_data_in;
        end
    end

    assign fill = din_sync[SYNC_STAGES-1];
`else
    assign fill = 1'b1;
`endif

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign load_s_n = load_sync[SYNC_STAGES-1];
    // Edges are ignored until the synchronisers have flushed their reset
    // values, so a joy_clk already high at release is not seen as a rise.
    assign rise     = clk_s & ~clk_prev & (mask_cnt == MASK_DONE);
    assign joy_data = sr[0];

    // Bit k of the frame is the k-th bit presented to the master.
    always_comb begin
        frame        = '1;
        frame[7:2]   = j1_sync[SYNC_STAGES-1];
        frame[15:10] = j2_sync[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync   <= '0;
            load_sync  <= '1;
            j1_sync    <= '1;
            j2_sync    <= '1;
            clk_prev   <= 1'b0;
            mask_cnt   <= '0;
            sr         <= '1;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                clk_sync[i]  <= clk_sync[i-1];
                load_sync[i] <= load_sync[i-1];
                j1_sync[i]   <= j1_sync[i-1];
                j2_sync[i]   <= j2_sync[i-1];
            end
            clk_sync[0]  <= joy_clk;
            load_sync[0] <= joy_load_n;
            j1_sync[0]   <= joy1_n;
            j2_sync[0]   <= joy2_n;

            clk_prev <= clk_s;
            if (mask_cnt != MASK_DONE) mask_cnt <= mask_cnt + 1'b1;

            frame_done <= 1'b0;
            // Load is level-sensitive and takes priority over a coincident rise.
            if (!load_s_n) begin
                sr      <= frame;
                bit_cnt <= '0;
            end else if (rise) begin
                sr <= {fill, sr[WIDTH-1:1]};
                // Saturating count gives exactly one frame_done per load.
                if (bit_cnt != CNT_MAX)  bit_cnt    <= bit_cnt + 1'b1;
                if (bit_cnt == CNT_LAST) frame_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_joy_serializer.sv
// Purpose     : self-checking bench for joy_serializer driven by a simple serial master.
// Latency     : master holds each joy_clk phase 4 clk and loads for 4 clk.
// Backpressure: not applicable.
module tb_joy_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       joy_clk = 1'b0;
    logic       joy_load_n = 1'b1;
    logic [5:0] joy1_n = 6'h3F;
    logic [5:0] joy2_n = 6'h3F;
    logic       joy_data;
    logic       frame_done;

`ifdef JOY_SERIALIZER_CASCADE_EN
    logic joy_data_in = 1'b0;
    localparam logic FILL = 1'b0;
`else
    localparam logic FILL = 1'b1;
`endif

    joy_serializer #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .joy_clk    (joy_clk),
        .joy_load_n (joy_load_n),
`ifdef JOY_SERIALIZER_CASCADE_EN
        .joy_data_in(joy_data_in),
`endif
        .joy1_n     (joy1_n),
        .joy2_n     (joy2_n),
        .joy_data   (joy_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  j1;
        logic [5:0]  j2;
        logic [15:0] word;
    } vec_t;

    vec_t tbl[5];
    logic exp_q[$];
    int   nvec = 0;
    int   nmis = 0;
    int   fd_cnt = 0;

    always @(negedge clk) if (frame_done) fd_cnt++;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) exp_q.push_back(i < 16 ? word[i] : FILL);
    endtask

    // Sample the presented bit (scoreboard pop), then clock one rise.
    task automatic shift_one(input int idx);
        logic e;
        if (exp_q.size() == 0) begin
            check($sformatf("sb_empty_bit%0d", idx), 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("bit%0d", idx), {31'd0, joy_data}, {31'd0, e});
        end
        joy_clk = 1'b1;
        tick(4);
        joy_clk = 1'b0;
        tick(4);
    endtask

    task automatic load_pulse();
        joy_load_n = 1'b0;
        tick(4);
        joy_load_n = 1'b1;
        tick(4);
    endtask

    // Clocks nbits bits already queued; checks frame_done is absent before
    // the 16th rise and seen exactly once overall.
    task automatic run_frame(input string name, input int nbits);
        int base;
        base = fd_cnt;
        for (int i = 0; i < nbits; i++) begin
            if (i == 15) check({name, "_fd_early"}, fd_cnt - base, 0);
            shift_one(i);
        end
        check({name, "_fd_count"}, fd_cnt - base, 1);
    endtask

    initial begin
        tbl[0] = '{6'b011111, 6'b111111, 16'hFF7F};
        tbl[1] = '{6'b111111, 6'b111110, 16'hFBFF};
        tbl[2] = '{6'b000000, 6'b000000, 16'h0303};
        tbl[3] = '{6'b111111, 6'b111111, 16'hFFFF};
        tbl[4] = '{6'b101010, 6'b010101, 16'h57AB};

        // Reset with joy_clk high across release: no spurious edge, so the
        // first frame_done needs a full 16 rises.
        joy_clk = 1'b1;
        tick(4);
        check("rst_joy_data", {31'd0, joy_data}, 32'd1);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        tick(8);
        check("post_rst_joy_data", {31'd0, joy_data}, 32'd1);
        joy_clk = 1'b0;
        tick(4);
        push_frame(16'hFFFF, 16);
        run_frame("noload", 16);

        // Table-driven frames.
        for (int v = 0; v < 5; v++) begin
            joy1_n = tbl[v].j1;
            joy2_n = tbl[v].j2;
            load_pulse();
            push_frame(tbl[v].word, 16);
            run_frame($sformatf("vec%0d", v), 16);
        end

        // Load held low across two rises while buttons change: no shift,
        // final word reflects the live buttons at release.
        joy1_n = tbl[2].j1;
        joy2_n = tbl[2].j2;
        joy_load_n = 1'b0;
        tick(4);
        joy_clk = 1'b1;
        tick(4);
        joy1_n = tbl[4].j1;
        joy2_n = tbl[4].j2;
        joy_clk = 1'b0;
        tick(4);
        joy_clk = 1'b1;
        tick(4);
        joy_clk = 1'b0;
        tick(4);
        joy_load_n = 1'b1;
        tick(4);
        push_frame(tbl[4].word, 16);
        run_frame("load_hold", 16);

        // Over-length read: fill bits appear, frame_done only once.
        joy1_n = tbl[2].j1;
        joy2_n = tbl[2].j2;
        load_pulse();
        push_frame(tbl[2].word, 20);
        run_frame("overrun", 20);

        // Reset mid-frame after 5 shifts, then a clean frame.
        load_pulse();
        push_frame(tbl[2].word, 5);
        for (int i = 0; i < 5; i++) shift_one(i);
        check("mid_bit5", {31'd0, joy_data}, 32'd0);
        reset = 1'b1;
        tick(1);
        check("mid_rst_joy_data", {31'd0, joy_data}, 32'd1);
        check("mid_rst_frame_done", {31'd0, frame_done}, 32'd0);
        tick(3);
        reset = 1'b0;
        tick(8);
        joy1_n = tbl[0].j1;
        joy2_n = tbl[0].j2;
        load_pulse();
        push_frame(tbl[0].word, 16);
        run_frame("after_rst", 16);

        check("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
